// File: rtl/cmn_elastic_pipe_reg_pkg.sv
// rtl/cmn_elastic_pipe_reg_pkg.sv - shared helpers for the elastic pipeline register
package cmn_elastic_pipe_reg_pkg;

  // Width needed to count 0..nstages occupied stages.
  function automatic int cnt_width(input int nstages);
    return $clog2(nstages + 1);
  endfunction

endpackage

// File: rtl/cmn_elastic_pipe_stage.sv
// rtl/cmn_elastic_pipe_stage.sv - one elastic stage: valid bit plus data register
// Load wins over clear so a stage can hand off and refill on the same edge.
module cmn_elastic_pipe_stage #(
  parameter int               p_nbits       = 32,
  parameter logic [p_nbits-1:0] p_reset_value = '0
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               load_i,
  input  logic               clear_i,
  input  logic [p_nbits-1:0] data_i,
  output logic               val_o,
  output logic [p_nbits-1:0] data_o
);

  logic               val_q;
  logic               val_d;
  logic [p_nbits-1:0] data_q;

  always_comb begin
    val_d = val_q;
    if (load_i) begin
      val_d = 1'b1;
    end else if (clear_i) begin
      val_d = 1'b0;
    end
  end

  // Data only toggles on a real write; invalid stages keep stale contents.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      val_q  <= 1'b0;
      data_q <= p_reset_value;
    end else begin
      val_q <= val_d;
      if (load_i) begin
        data_q <= data_i;
      end
    end
  end

  assign val_o  = val_q;
  assign data_o = data_q;

endmodule

// File: rtl/cmn_elastic_pipe_reg.sv
// rtl/cmn_elastic_pipe_reg.sv - N-stage elastic pipeline register with val/rdy on both sides
// Bubbles collapse under backpressure; ready ripples combinationally from output to input.
module cmn_elastic_pipe_reg
  import cmn_elastic_pipe_reg_pkg::*;
#(
  parameter int                 p_nbits       = 32,
  parameter int                 p_nstages     = 2,
  parameter logic [p_nbits-1:0] p_reset_value = '0
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           flush,
  input  logic                           istream_val,
  output logic                           istream_rdy,
  input  logic [p_nbits-1:0]             istream_msg,
  output logic                           ostream_val,
  input  logic                           ostream_rdy,
  output logic [p_nbits-1:0]             ostream_msg,
  output logic [$clog2(p_nstages+1)-1:0] count
);

  localparam int c_cnt_w = cnt_width(p_nstages);

  logic [p_nstages-1:0] val;
  logic [p_nstages-1:0] go;
  logic [p_nstages-1:0] load;
  logic [p_nstages-1:0] clear;
  logic [p_nbits-1:0]   data [p_nstages];
  logic                 in_room;
  logic                 in_fire;
  logic                 out_fire;
  logic [c_cnt_w-1:0]   count_q;
  logic [c_cnt_w-1:0]   count_d;

  // Walk from the output back: a stage hands off if it is valid and the next one has room.
  always_comb begin
    logic room;
    go   = '0;
    room = ostream_rdy;
    for (int s = p_nstages - 1; s >= 0; s--) begin
      go[s] = val[s] && room;
      room  = !val[s] || go[s];
    end
    in_room = room;
  end

  assign istream_rdy = !flush && !reset && in_room;
  assign in_fire     = istream_val && istream_rdy;
  assign ostream_val = val[p_nstages-1] && !reset;
  assign out_fire    = ostream_val && ostream_rdy;

  for (genvar s = 0; s < p_nstages; s++) begin : g_stage
    if (s == 0) begin : g_first
      assign load[s] = in_fire;
      cmn_elastic_pipe_stage #(
        .p_nbits       (p_nbits),
        .p_reset_value (p_reset_value)
      ) u_stage (
        .clk_i   (clk),
        .reset_i (reset),
        .load_i  (load[s]),
        .clear_i (clear[s]),
        .data_i  (istream_msg),
        .val_o   (val[s]),
        .data_o  (data[s])
      );
    end else begin : g_rest
      assign load[s] = go[s-1] && !flush;
      cmn_elastic_pipe_stage #(
        .p_nbits       (p_nbits),
        .p_reset_value (p_reset_value)
      ) u_stage (
        .clk_i   (clk),
        .reset_i (reset),
        .load_i  (load[s]),
        .clear_i (clear[s]),
        .data_i  (data[s-1]),
        .val_o   (val[s]),
        .data_o  (data[s])
      );
    end
    assign clear[s] = go[s] || flush;
  end

  always_comb begin
    count_d = count_q + c_cnt_w'(in_fire) - c_cnt_w'(out_fire);
    if (flush) begin
      count_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count       = reset ? '0 : count_q;
  assign ostream_msg = reset ? p_reset_value : data[p_nstages-1];

endmodule
